serial_crossbar: RTL and testbench
==================================

# serial_crossbar

Multi-route successor to the single-path serial bus interconnect. It sits between the arbiter and the serial master/slave ports. It holds a registered route table so that every master can own a distinct slave concurrently. Routes tear themselves down on the last beat, on an explicit disconnect, or on an idle timeout, and each teardown is reported back to the arbiter.

## Interface
- NO_MASTERS, 2, number of master ports
- NO_SLAVES, 3, number of slave ports
- DATA_WIDTH, 1, lane width of wD/rD (1 = classic serial)
- TIMEOUT, 16, idle cycles before forced release; 0 disables
- M_ID_WIDTH, $clog2(NO_MASTERS), master id width
- S_ID_WIDTH, $clog2(NO_SLAVES+1), slave code width; 0 = none, k = slave k-1
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_valid  in  1  route command strobe; always accepted
- cfg_master  in  M_ID_WIDTH  master addressed
- cfg_slave  in  S_ID_WIDTH  slave code; 0 = disconnect
- cfg_ack  out  1  command applied (registered pulse)
- cfg_err  out  1  command rejected (registered pulse)
- busy_M  out  [NO_MASTERS]  master currently routed
- rel_M  out  [NO_MASTERS]  route released (registered pulse)
- timeout_M  out  [NO_MASTERS]  release was caused by timeout (with rel_M)
- control_M, valid_M, last_M  in  1 each, [0:NO_MASTERS-1]  master request lines
- wD_M  in  DATA_WIDTH, [0:NO_MASTERS-1]  master write data
- rD_M  out  DATA_WIDTH, [0:NO_MASTERS-1]  read data to master
- ready_M  out  1, [0:NO_MASTERS-1]  ready to master
- control_S, valid_S, last_S  out  1 each, [0:NO_SLAVES-1]  slave request lines
- wD_S  out  DATA_WIDTH, [0:NO_SLAVES-1]  slave write data
- rD_S  in  DATA_WIDTH, [0:NO_SLAVES-1]  slave read data
- ready_S  in  1, [0:NO_SLAVES-1]  slave ready

## Operation
- Route table: route[m] holds a slave code. owner[s] is derived from it; at most one master per slave.
- Per-master FSM, states IDLE and LINKED.
  - IDLE→LINKED on an accepted connect.
  - LINKED→IDLE on any of: last beat (valid_M & last_M & ready_M); cfg disconnect; idle count reaching TIMEOUT.
- Connect (cfg_slave≠0): accepted only if all of the following hold, otherwise cfg_err and no state change:
  - master is IDLE;
  - cfg_master < NO_MASTERS;
  - cfg_slave ≤ NO_SLAVES;
  - target slave is unowned in the registered table.
- Disconnect (cfg_slave=0):
  - master LINKED → route cleared, cfg_ack, rel_M pulse.
  - master IDLE → cfg_ack only.
- Datapath is combinational through the registered table.
  - Routed slave sees its master's control/wD/valid/last.
  - Routed master sees its slave's rD/ready.
- Unowned slave: all outputs 0. Unrouted master: ready_M=1, rD_M=0.
- Idle counter, per master:
  - cleared on entry to LINKED and on every cycle with valid_M=1;
  - otherwise increments while LINKED.
  - Reaching TIMEOUT forces release with rel_M and timeout_M.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- Simultaneous events:
  - cfg is evaluated against pre-edge state. A connect to a slave whose owner releases in the same cycle gets cfg_err.
  - A disconnect coinciding with a last beat or timeout yields one rel_M pulse, with timeout_M=0.
  - Several masters may release in the same cycle; each has its own rel_M bit.

## Timing
- Reset (asynchronous, active-high) values:
  - route all 0; FSMs IDLE; counters 0;
  - cfg_ack=cfg_err=0; busy_M=rel_M=timeout_M=0;
  - ready_M all 1; rD_M all 0; all slave outputs 0.
- Asserting rst mid-transfer drops every route immediately. No rel_M is issued.
- cfg is sampled at edge N. The route is active, and cfg_ack/cfg_err are high, during cycle N+1.
- A last-beat handshake in cycle N tears the route down at edge N+1. The slave sees zeros and rel_M pulses in cycle N+1.
- Data latency master→slave and slave→master: 0 cycles.
- A master may be reconnected by a cfg in the same cycle as its rel_M pulse.

## Structure
- serial_bus_pkg: link_state_e (IDLE, LINKED), SLAVE_NONE=0, and id-width helper functions.
- Sub-module link_ctrl, one per master: FSM, idle counter, release and timeout flags.
- The top level holds the route table, cfg checking and the mux/demux fabric.

## Test plan
All scenarios use NO_MASTERS=2, NO_SLAVES=3, TIMEOUT=8.
- Concurrent routes: connect M0→code 1 and M1→code 3 → cfg_ack each; M0 bits appear only on S0, M1 only on S2; S1 outputs stay 0.
- Conflict: M0 owns code 2; cfg M1→code 2 → cfg_err=1, table unchanged, S1 still driven by M0.
- Last beat: M0 sends 5 beats with last on the 5th while ready_S=1 → rel_M[0] one cycle later; busy_M[0]=0; ready_M[0]=1.
- Timeout: M1 linked, valid_M=0 for 8 cycles → rel_M[1]=timeout_M[1]=1 on the next cycle; valid pulse at cycle 5 restarts the count.
- Same-cycle release/connect: M0 last beat while cfg M1→same slave → cfg_err; retry next cycle → cfg_ack.
- Reset mid-transfer: rst during M0 beat 3 → all slave outputs 0, ready_M all 1, no rel_M.

Source files
------------

// File: rtl/serial_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_bus_pkg
// Description : Shared types, constants and width helpers for the serial
//               crossbar and its per-master link controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_bus_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LINKED = 1'b1
    } link_state_e;

    // Slave code 0 means "no slave"; code k addresses slave k-1.
    localparam int SLAVE_NONE = 0;

    // Master id width; kept at least 1 so a single-master build still has a port.
    function automatic int master_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Slave code width, room for codes 0..n.
    function automatic int slave_code_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Idle counter width; a disabled timeout still needs a 1-bit counter.
    function automatic int count_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : link_ctrl
// Description : Per-master link FSM (IDLE/LINKED) with idle counter, release
//               detection and registered release / timeout pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module link_ctrl
    import serial_bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_connect,
    input  logic i_disconnect,
    input  logic i_valid,
    input  logic i_last,
    input  logic i_ready,
    output logic o_busy,
    output logic o_release_now,
    output logic o_rel,
    output logic o_timeout
);

    localparam int CNT_W = count_width(TIMEOUT);
    // Release fires on the idle cycle that would bring the count to TIMEOUT.
    localparam logic [CNT_W-1:0] C_LAST_IDLE = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] C_CNT_MAX   = CNT_W'(TIMEOUT);

    link_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rel_q, rel_d;
    logic             tmo_q, tmo_d;
    logic             w_last_beat;
    logic             w_timeout_hit;

    // Next-state, idle counter and release decision from pre-edge state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rel_d         = 1'b0;
        tmo_d         = 1'b0;
        w_last_beat   = (state_q == LINKED) && i_valid && i_last && i_ready;
        w_timeout_hit = (TIMEOUT > 0) && (state_q == LINKED) && !i_valid
                        && (cnt_q == C_LAST_IDLE);
        o_release_now = (state_q == LINKED) && (w_last_beat || i_disconnect || w_timeout_hit);
        case (state_q)
            IDLE: begin
                if (i_connect) begin
                    state_d = LINKED;
                    cnt_d   = '0;
                end
            end
            LINKED: begin
                if (o_release_now) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                    // An explicit disconnect takes precedence over the timeout cause.
                    tmo_d   = w_timeout_hit && !i_disconnect;
                end else if (i_valid) begin
                    cnt_d = '0;
                end else if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Link state, counter and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_busy    = (state_q == LINKED);
    assign o_rel     = rel_q;
    assign o_timeout = tmo_q;

endmodule
`default_nettype wire

// File: rtl/serial_crossbar.sv
`default_nettype none
// ============================================================================
// Module      : serial_crossbar
// Description : Multi-route serial interconnect. Registered route table,
//               route command checking and combinational mux/demux fabric.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_crossbar
    import serial_bus_pkg::*;
#(
    parameter int NO_MASTERS = 2,
    parameter int NO_SLAVES  = 3,
    parameter int DATA_WIDTH = 1,
    parameter int TIMEOUT    = 16,
    parameter int M_ID_WIDTH = master_id_width(NO_MASTERS),
    parameter int S_ID_WIDTH = slave_code_width(NO_SLAVES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [M_ID_WIDTH-1:0] cfg_master,
    input  logic [S_ID_WIDTH-1:0] cfg_slave,
    output logic                  cfg_ack,
    output logic                  cfg_err,
    output logic [NO_MASTERS-1:0] busy_M,
    output logic [NO_MASTERS-1:0] rel_M,
    output logic [NO_MASTERS-1:0] timeout_M,
    input  logic [NO_MASTERS-1:0] control_M,
    input  logic [NO_MASTERS-1:0] valid_M,
    input  logic [NO_MASTERS-1:0] last_M,
    input  logic [DATA_WIDTH-1:0] wD_M [0:NO_MASTERS-1],
    output logic [DATA_WIDTH-1:0] rD_M [0:NO_MASTERS-1],
    output logic [NO_MASTERS-1:0] ready_M,
    output logic [NO_SLAVES-1:0]  control_S,
    output logic [NO_SLAVES-1:0]  valid_S,
    output logic [NO_SLAVES-1:0]  last_S,
    output logic [DATA_WIDTH-1:0] wD_S [0:NO_SLAVES-1],
    input  logic [DATA_WIDTH-1:0] rD_S [0:NO_SLAVES-1],
    input  logic [NO_SLAVES-1:0]  ready_S
);

    logic [S_ID_WIDTH-1:0] route_q [0:NO_MASTERS-1];
    logic [S_ID_WIDTH-1:0] route_d [0:NO_MASTERS-1];
    logic                  cfg_ack_q, cfg_ack_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [NO_MASTERS-1:0] w_connect;
    logic [NO_MASTERS-1:0] w_disconnect;
    logic [NO_MASTERS-1:0] w_release;
    logic                  w_master_ok;
    logic                  w_slave_ok;
    logic                  w_is_disc;
    logic                  w_target_owned;
    logic                  w_master_busy;
    logic                  w_accept;

    assign w_master_ok = (32'(cfg_master) < 32'(NO_MASTERS));
    assign w_slave_ok  = (32'(cfg_slave) <= 32'(NO_SLAVES));
    assign w_is_disc   = (cfg_slave == S_ID_WIDTH'(SLAVE_NONE));

    // Route command checking against the registered table and link states.
    always_comb begin
        cfg_ack_d      = 1'b0;
        cfg_err_d      = 1'b0;
        w_connect      = '0;
        w_disconnect   = '0;
        w_target_owned = 1'b0;
        w_master_busy  = 1'b0;
        for (int m = 0; m < NO_MASTERS; m++) begin
            if (route_q[m] == cfg_slave) w_target_owned = 1'b1;
            if ((M_ID_WIDTH'(m) == cfg_master) && busy_M[m]) w_master_busy = 1'b1;
        end
        w_accept = w_master_ok && w_slave_ok && !w_is_disc && !w_target_owned && !w_master_busy;
        if (cfg_valid) begin
            if (!w_master_ok) begin
                cfg_err_d = 1'b1;
            end else if (w_is_disc || w_accept) begin
                cfg_ack_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
        for (int m = 0; m < NO_MASTERS; m++) begin
            if (cfg_valid && w_master_ok && (M_ID_WIDTH'(m) == cfg_master)) begin
                w_disconnect[m] = w_is_disc;
                w_connect[m]    = w_accept;
            end
        end
    end

    // Route table next state: teardown wins, otherwise apply an accepted connect.
    always_comb begin
        for (int m = 0; m < NO_MASTERS; m++) begin
            route_d[m] = route_q[m];
            if (w_release[m]) begin
                route_d[m] = '0;
            end else if (w_connect[m]) begin
                route_d[m] = cfg_slave;
            end
        end
    end

    // Route table and command response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < NO_MASTERS; m++) route_q[m] <= '0;
            cfg_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int m = 0; m < NO_MASTERS; m++) route_q[m] <= route_d[m];
            cfg_ack_q <= cfg_ack_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_ack = cfg_ack_q;
    assign cfg_err = cfg_err_q;

    // Mux/demux fabric steered by the registered route table.
    always_comb begin
        control_S = '0;
        valid_S   = '0;
        last_S    = '0;
        ready_M   = '1;
        for (int s = 0; s < NO_SLAVES; s++) wD_S[s] = '0;
        for (int m = 0; m < NO_MASTERS; m++) rD_M[m] = '0;
        for (int m = 0; m < NO_MASTERS; m++) begin
            for (int s = 0; s < NO_SLAVES; s++) begin
                if (route_q[m] == S_ID_WIDTH'(s + 1)) begin
                    control_S[s] = control_M[m];
                    valid_S[s]   = valid_M[m];
                    last_S[s]    = last_M[m];
                    wD_S[s]      = wD_M[m];
                    ready_M[m]   = ready_S[s];
                    rD_M[m]      = rD_S[s];
                end
            end
        end
    end

    generate
        for (genvar m = 0; m < NO_MASTERS; m++) begin : g_link
            link_ctrl #(
                .TIMEOUT (TIMEOUT)
            ) u_link (
                .clk           (clk),
                .rst           (rst),
                .i_connect     (w_connect[m]),
                .i_disconnect  (w_disconnect[m]),
                .i_valid       (valid_M[m]),
                .i_last        (last_M[m]),
                .i_ready       (ready_M[m]),
                .o_busy        (busy_M[m]),
                .o_release_now (w_release[m]),
                .o_rel         (rel_M[m]),
                .o_timeout     (timeout_M[m])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_serial_crossbar.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_crossbar
// Description : Scoreboard bench for serial_crossbar (2 masters, 3 slaves,
//               TIMEOUT=8): routing, conflicts, last beat, timeout, races, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_crossbar;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int DW = 1;
    localparam int TMO = 8;
    localparam int MW = 1;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic [MW-1:0] cfg_master;
    logic [SW-1:0] cfg_slave;
    logic          cfg_ack, cfg_err;
    logic [NM-1:0] busy_M, rel_M, timeout_M;
    logic [NM-1:0] control_M, valid_M, last_M, ready_M;
    logic [DW-1:0] wD_M [0:NM-1];
    logic [DW-1:0] rD_M [0:NM-1];
    logic [NS-1:0] control_S, valid_S, last_S, ready_S;
    logic [DW-1:0] wD_S [0:NS-1];
    logic [DW-1:0] rD_S [0:NS-1];

    typedef struct { int due; logic ack; logic err; } cfg_exp_t;
    typedef struct { int due; logic [NM-1:0] rel; logic [NM-1:0] tmo; } rel_exp_t;

    cfg_exp_t cfg_sb[$];
    rel_exp_t rel_sb[$];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    serial_crossbar #(
        .NO_MASTERS (NM),
        .NO_SLAVES  (NS),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_master (cfg_master),
        .cfg_slave  (cfg_slave),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .busy_M     (busy_M),
        .rel_M      (rel_M),
        .timeout_M  (timeout_M),
        .control_M  (control_M),
        .valid_M    (valid_M),
        .last_M     (last_M),
        .wD_M       (wD_M),
        .rD_M       (rD_M),
        .ready_M    (ready_M),
        .control_S  (control_S),
        .valid_S    (valid_S),
        .last_S     (last_S),
        .wD_S       (wD_S),
        .rD_S       (rD_S),
        .ready_S    (ready_S)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] sword(input int s);
        return {control_S[s], valid_S[s], last_S[s], wD_S[s][0]};
    endfunction

    function automatic logic [3:0] mword(input int m);
        return {control_M[m], valid_M[m], last_M[m], wD_M[m][0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a release pulse in the cycle after the current one.
    task automatic exp_rel(input logic [NM-1:0] r, input logic [NM-1:0] t);
        rel_sb.push_back('{cyc + 1, r, t});
    endtask

    // Issue one route command this cycle and record the expected response.
    task automatic do_cfg(input int m, input int s, input logic ack, input logic [NM-1:0] rel_exp);
        cfg_valid  = 1'b1;
        cfg_master = MW'(m);
        cfg_slave  = SW'(s);
        cfg_sb.push_back('{cyc + 1, ack, !ack});
        if (rel_exp != '0) exp_rel(rel_exp, '0);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy_M, 0);
        chk({tag, "_ready_M"}, ready_M, 2'b11);
        chk({tag, "_rD_M0"}, rD_M[0], 0);
        chk({tag, "_rD_M1"}, rD_M[1], 0);
        chk({tag, "_S0"}, sword(0), 0);
        chk({tag, "_S1"}, sword(1), 0);
        chk({tag, "_S2"}, sword(2), 0);
        chk({tag, "_rel"}, {rel_M, timeout_M}, 0);
        chk({tag, "_cfg"}, {cfg_ack, cfg_err}, 0);
    endtask

    // Scoreboard monitor: pops expected responses when they fall due.
    always @(negedge clk) begin : mon
        cfg_exp_t ce;
        rel_exp_t re;
        if (cfg_sb.size() > 0 && cfg_sb[0].due == cyc) begin
            ce = cfg_sb.pop_front();
            chk("cfg_ack", cfg_ack, ce.ack);
            chk("cfg_err", cfg_err, ce.err);
        end else if (cfg_ack || cfg_err) begin
            chk("cfg_spurious", {cfg_ack, cfg_err}, 0);
        end
        if (rel_sb.size() > 0 && rel_sb[0].due == cyc) begin
            re = rel_sb.pop_front();
            chk("rel_M", rel_M, re.rel);
            chk("timeout_M", timeout_M, re.tmo);
        end else if (rel_M != '0 || timeout_M != '0) begin
            chk("rel_spurious", {rel_M, timeout_M}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_master = '0;
        cfg_slave  = '0;
        control_M  = '0;
        valid_M    = 2'b11;
        last_M     = '0;
        wD_M[0]    = '0;
        wD_M[1]    = '0;
        for (int s = 0; s < NS; s++) rD_S[s] = '0;
        ready_S    = '0;
        tick();
        tick();
        rst = 1'b0;
        #2;
        check_idle("reset");

        // Concurrent routes: M0 -> S0, M1 -> S2, S1 untouched.
        tick();
        do_cfg(0, 1, 1'b1, '0);
        do_cfg(1, 3, 1'b1, '0);
        rD_S[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            control_M = NM'($urandom);
            wD_M[0]   = DW'($urandom);
            wD_M[1]   = DW'($urandom);
            rD_S[0]   = DW'($urandom);
            rD_S[2]   = DW'($urandom);
            ready_S   = NS'($urandom);
            #2;
            chk("cc_S0", sword(0), mword(0));
            chk("cc_S2", sword(2), mword(1));
            chk("cc_S1", sword(1), 0);
            chk("cc_rD_M0", rD_M[0], rD_S[0]);
            chk("cc_rD_M1", rD_M[1], rD_S[2]);
            chk("cc_ready_M", ready_M, {ready_S[2], ready_S[0]});
            tick();
        end
        chk("cc_busy", busy_M, 2'b11);
        do_cfg(0, 0, 1'b1, 2'b01);
        do_cfg(1, 0, 1'b1, 2'b10);
        do_cfg(1, 0, 1'b1, '0);
        #2;
        chk("disc_busy", busy_M, 0);

        // Conflict: M1 may not take S1 while M0 owns it.
        control_M = 2'b01;
        wD_M[0]   = 1'b1;
        do_cfg(0, 2, 1'b1, '0);
        do_cfg(1, 2, 1'b0, '0);
        #2;
        chk("cf_busy", busy_M, 2'b01);
        chk("cf_S1", sword(1), mword(0));
        chk("cf_S0", sword(0), 0);
        do_cfg(0, 0, 1'b1, 2'b01);

        // Last beat: five beats, last on the fifth, slave always ready.
        ready_S = 3'b001;
        do_cfg(0, 1, 1'b1, '0);
        for (int b = 1; b <= 5; b++) begin
            control_M[0] = 1'b1;
            wD_M[0]      = DW'(b);
            last_M[0]    = (b == 5);
            #2;
            chk("lb_S0", sword(0), mword(0));
            if (b == 5) exp_rel(2'b01, 2'b00);
            tick();
        end
        last_M  = '0;
        ready_S = '0;
        #2;
        chk("lb_busy", busy_M, 0);
        chk("lb_ready_M0", ready_M[0], 1);
        chk("lb_S0_after", sword(0), 0);

        // Timeout with a valid pulse on the fifth linked cycle.
        tick();
        valid_M[1] = 1'b0;
        do_cfg(1, 2, 1'b1, '0);
        repeat (4) tick();
        valid_M[1] = 1'b1;
        tick();
        valid_M[1] = 1'b0;
        repeat (7) tick();
        #2;
        chk("to_busy_before", busy_M, 2'b10);
        exp_rel(2'b10, 2'b10);
        tick();
        #2;
        chk("to_busy_after", busy_M, 0);
        valid_M[1] = 1'b1;

        // Same-cycle release and connect to the releasing slave.
        ready_S = 3'b001;
        do_cfg(0, 1, 1'b1, '0);
        tick();
        last_M[0] = 1'b1;
        exp_rel(2'b01, 2'b00);
        do_cfg(1, 1, 1'b0, '0);
        last_M[0] = 1'b0;
        do_cfg(1, 1, 1'b1, '0);
        control_M = 2'b10;
        wD_M[1]   = 1'b1;
        #2;
        chk("race_busy", busy_M, 2'b10);
        chk("race_S0", sword(0), mword(1));
        do_cfg(1, 0, 1'b1, 2'b10);

        // Reset in the middle of a transfer.
        control_M = 2'b01;
        do_cfg(0, 1, 1'b1, '0);
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_S0", sword(0), 0);
        chk("rst_mid_ready_M", ready_M, 2'b11);
        chk("rst_mid_busy", busy_M, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        #2;
        check_idle("post_rst");

        chk("cfg_sb_drain", cfg_sb.size(), 0);
        chk("rel_sb_drain", rel_sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
